// File: rtl/tds_frame_aligner_if.sv
// Receive-side bus between the GTP wrapper/link monitor and the TDS frame aligner.
// The master drives the raw words and controls; the slave returns aligned data and link stats.
interface tds_frame_aligner_if;
    logic [19:0] rx_data_in;
    logic        rx_valid_in;
    logic        check_en;
    logic        clear_cnt;
    logic [19:0] aligned_data_out;
    logic        aligned_valid_out;
    logic        frame_start_out;
    logic        locked_out;
    logic [4:0]  bit_offset_out;
    logic [15:0] sync_err_cnt;
    logic [31:0] payload_err_cnt;
    logic [7:0]  lock_loss_cnt;

    modport master (
        output rx_data_in, rx_valid_in, check_en, clear_cnt,
        input  aligned_data_out, aligned_valid_out, frame_start_out, locked_out,
        input  bit_offset_out, sync_err_cnt, payload_err_cnt, lock_loss_cnt
    );

    modport slave (
        input  rx_data_in, rx_valid_in, check_en, clear_cnt,
        output aligned_data_out, aligned_valid_out, frame_start_out, locked_out,
        output bit_offset_out, sync_err_cnt, payload_err_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/tds_frame_aligner.sv
// TDS frame aligner: hunts the sync word at any of 20 bit offsets, verifies, locks,
// emits frame-aligned words and keeps saturating sync/payload/lock-loss counters.
module tds_frame_aligner #(
    parameter logic [19:0] SYNC_WORD  = 20'hBC5A3,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input logic                 data_clk,
    input logic                 reset_n,
    tds_frame_aligner_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e            state_q, state_d;
    logic [19:0]       prev_word_q, prev_word_d;
    logic [IdxW-1:0]   idx_q, idx_d, slot;
    logic [4:0]        off_q, off_d;
    logic [3:0]        good_q, good_d, bad_q, bad_d;
    logic [19:0]       exp_q, exp_d;
    logic              seeded_q, seeded_d;
    logic [19:0]       data_q, data_d;
    logic              valid_q, valid_d, fs_q, fs_d;
    logic [15:0]       sync_err_q, sync_err_d;
    logic [31:0]       payload_err_q, payload_err_d;
    logic [7:0]        lock_loss_q, lock_loss_d;
    logic [39:0]       window;
    logic [19:0]       cand;
    logic              hit;
    logic [4:0]        hit_k;
    logic              serr_inc, perr_inc, loss_inc;

    assign window = {bus.rx_data_in, prev_word_q};
    assign cand   = window[{1'b0, off_q} +: 20];

    // Descending scan so the lowest matching offset is the one that sticks.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = 19; k >= 0; k--) begin
            if (window[k +: 20] == SYNC_WORD) begin
                hit   = 1'b1;
                hit_k = 5'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_word_d = prev_word_q;
        idx_d       = idx_q;
        off_d       = off_q;
        good_d      = good_q;
        bad_d       = bad_q;
        exp_d       = exp_q;
        seeded_d    = seeded_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        fs_d        = 1'b0;
        serr_inc    = 1'b0;
        perr_inc    = 1'b0;
        loss_inc    = 1'b0;
        slot        = idx_q;

        // Payload seed is dropped whenever checking is not live, so re-entry reseeds.
        if (state_q != StLocked || !bus.check_en) seeded_d = 1'b0;

        if (bus.rx_valid_in) begin
            prev_word_d = bus.rx_data_in;
            unique case (state_q)
                StHunt: begin
                    if (hit) begin
                        off_d   = hit_k;
                        slot    = '0;
                        good_d  = 4'd1;
                        bad_d   = '0;
                        state_d = (LOCK_CNT == 1) ? StLocked : StVerify;
                    end
                end
                StVerify: begin
                    if (slot == '0) begin
                        if (cand == SYNC_WORD) begin
                            good_d = good_q + 4'd1;
                            bad_d  = '0;
                            if (good_q + 4'd1 == 4'(LOCK_CNT)) state_d = StLocked;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                StLocked: begin
                    if (slot == '0) begin
                        if (cand == SYNC_WORD) begin
                            bad_d = '0;
                        end else begin
                            bad_d    = bad_q + 4'd1;
                            serr_inc = 1'b1;
                            if (bad_q + 4'd1 == 4'(UNLOCK_CNT)) begin
                                state_d  = StHunt;
                                loss_inc = 1'b1;
                            end
                        end
                    end else if (bus.check_en) begin
                        seeded_d = 1'b1;
                        if (!seeded_q) begin
                            exp_d = cand + 20'd1;
                        end else if (cand == exp_q) begin
                            exp_d = exp_q + 20'd1;
                        end else begin
                            perr_inc = 1'b1;
                            exp_d    = cand + 20'd1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
            idx_d   = (slot == IdxW'(FRAME_LEN - 1)) ? '0 : slot + 1'b1;
            data_d  = window[{1'b0, off_d} +: 20];
            valid_d = (state_d == StLocked);
            fs_d    = valid_d && (slot == '0);
        end

        sync_err_d = sync_err_q;
        if (bus.clear_cnt) sync_err_d = '0;
        else if (serr_inc && sync_err_q != '1) sync_err_d = sync_err_q + 16'd1;

        payload_err_d = payload_err_q;
        if (bus.clear_cnt) payload_err_d = '0;
        else if (perr_inc && payload_err_q != '1) payload_err_d = payload_err_q + 32'd1;

        lock_loss_d = lock_loss_q;
        if (bus.clear_cnt) lock_loss_d = '0;
        else if (loss_inc && lock_loss_q != '1) lock_loss_d = lock_loss_q + 8'd1;
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StHunt;
            prev_word_q   <= '0;
            idx_q         <= '0;
            off_q         <= '0;
            good_q        <= '0;
            bad_q         <= '0;
            exp_q         <= '0;
            seeded_q      <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            fs_q          <= 1'b0;
            sync_err_q    <= '0;
            payload_err_q <= '0;
            lock_loss_q   <= '0;
        end else begin
            state_q       <= state_d;
            prev_word_q   <= prev_word_d;
            idx_q         <= idx_d;
            off_q         <= off_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            exp_q         <= exp_d;
            seeded_q      <= seeded_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            fs_q          <= fs_d;
            sync_err_q    <= sync_err_d;
            payload_err_q <= payload_err_d;
            lock_loss_q   <= lock_loss_d;
        end
    end

    assign bus.aligned_data_out  = data_q;
    assign bus.aligned_valid_out = valid_q;
    assign bus.frame_start_out   = fs_q;
    assign bus.locked_out        = (state_q == StLocked);
    assign bus.bit_offset_out    = off_q;
    assign bus.sync_err_cnt      = sync_err_q;
    assign bus.payload_err_cnt   = payload_err_q;
    assign bus.lock_loss_cnt     = lock_loss_q;
endmodule

// File: tb/tb_tds_frame_aligner.sv
// Bench for tds_frame_aligner: a serial bit stream is built from frames, chopped into raw
// words and compared every cycle against a bit-window reference model of the link rules.
module tb_tds_frame_aligner;
    localparam logic [19:0] SYNC = 20'hBC5A3;
    localparam int FLEN = 16;
    localparam int LCNT = 4;
    localparam int UCNT = 4;

    logic data_clk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 data_clk = ~data_clk;

    tds_frame_aligner_if bus ();

    tds_frame_aligner #(
        .SYNC_WORD (SYNC),
        .FRAME_LEN (FLEN),
        .LOCK_CNT  (LCNT),
        .UNLOCK_CNT(UCNT)
    ) dut (
        .data_clk(data_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit bits[$];
    logic [19:0] pay;
    bit gap_en = 0;
    bit fs_chk = 0;

    // Reference model state: 0 hunt, 1 verify, 2 locked; slot derived from word counts.
    int          m_st, m_off, m_good, m_bad;
    longint      m_n, m_base, m_serr, m_perr, m_loss;
    logic [19:0] m_prev, m_exp;
    bit          m_seeded;
    logic [19:0] e_data;
    bit          e_av, e_fs;

    task automatic model_reset();
        m_st = 0; m_off = 0; m_good = 0; m_bad = 0;
        m_n = 0; m_base = 0; m_serr = 0; m_perr = 0; m_loss = 0;
        m_prev = '0; m_exp = '0; m_seeded = 0;
        e_data = '0; e_av = 0; e_fs = 0;
    endtask

    task automatic model_step(input logic [19:0] w, input bit v);
        logic [39:0] win;
        logic [19:0] c;
        int st0, slot;
        st0 = m_st;
        if (st0 != 2 || !bus.check_en) m_seeded = 0;
        if (v) begin
            win  = {w, m_prev};
            slot = int'((m_n - m_base) % FLEN);
            if (st0 == 0) begin
                slot = -1;
                for (int k = 0; k < 20; k++) begin
                    if (win[k +: 20] == SYNC) begin
                        m_off = k; m_base = m_n; m_good = 1; m_bad = 0; slot = 0;
                        m_st = (LCNT == 1) ? 2 : 1;
                        break;
                    end
                end
            end else begin
                c = win[m_off +: 20];
                if (slot == 0 && st0 == 1) begin
                    if (c == SYNC) begin
                        m_good++;
                        m_bad = 0;
                        if (m_good == LCNT) m_st = 2;
                    end else m_st = 0;
                end else if (slot == 0) begin
                    if (c == SYNC) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_serr < 65535) m_serr++;
                        if (m_bad == UCNT) begin
                            m_st = 0;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                end else if (st0 == 2 && bus.check_en) begin
                    if (!m_seeded) m_exp = c + 20'd1;
                    else if (c == m_exp) m_exp = m_exp + 20'd1;
                    else begin
                        if (m_perr < 64'hFFFF_FFFF) m_perr++;
                        m_exp = c + 20'd1;
                    end
                    m_seeded = 1;
                end
            end
            e_data = win[m_off +: 20];
            e_av   = (m_st == 2);
            e_fs   = e_av && (slot == 0);
            m_prev = w;
            m_n++;
        end else begin
            e_av = 0;
            e_fs = 0;
        end
        if (bus.clear_cnt) begin
            m_serr = 0; m_perr = 0; m_loss = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("aligned_data", 32'(bus.aligned_data_out), 32'(e_data));
        chk("aligned_valid", 32'(bus.aligned_valid_out), 32'(e_av));
        chk("frame_start", 32'(bus.frame_start_out), 32'(e_fs));
        chk("locked", 32'(bus.locked_out), 32'(m_st == 2));
        chk("bit_offset", 32'(bus.bit_offset_out), 32'(m_off));
        chk("sync_err", 32'(bus.sync_err_cnt), 32'(m_serr));
        chk("payload_err", bus.payload_err_cnt, 32'(m_perr));
        chk("lock_loss", 32'(bus.lock_loss_cnt), 32'(m_loss));
        if (fs_chk && e_fs) chk("fs_holds_sync", 32'(bus.aligned_data_out), 32'(SYNC));
    endtask

    task automatic drive(input logic [19:0] w, input bit v);
        bus.rx_data_in  = w;
        bus.rx_valid_in = v;
        @(posedge data_clk);
        model_step(w, v);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_locked", 32'(bus.locked_out), 32'd0);
        chk("rst_data", 32'(bus.aligned_data_out), 32'd0);
        @(posedge data_clk);
        @(negedge data_clk);
        reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [19:0] w);
        for (int i = 0; i < 20; i++) bits.push_back(w[i]);
    endtask

    task automatic drain(input int reset_at);
        logic [19:0] w;
        int cnt;
        cnt = 0;
        while (bits.size() >= 20) begin
            for (int i = 0; i < 20; i++) w[i] = bits.pop_front();
            if (gap_en && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) begin
                    drive(20'($urandom), 1'b0);
                    chk("gap_valid_low", 32'(bus.aligned_valid_out), 32'd0);
                end
            end
            drive(w, 1'b1);
            cnt++;
            if (cnt == reset_at) pulse_reset();
        end
    endtask

    // good=0 puts a one-bit-damaged sync in slot 0; fake puts SYNC into a payload slot.
    task automatic frame(input bit good, input int corrupt, input int fake, input int reset_at);
        logic [19:0] w;
        w = SYNC;
        if (!good) w = SYNC ^ (20'h1 << $urandom_range(0, 19));
        push_word(w);
        for (int s = 1; s < FLEN; s++) begin
            w = pay;
            if (s == corrupt) w = w ^ 20'h0F0F0;
            if (s == fake) w = SYNC;
            push_word(w);
            pay = pay + 20'd1;
        end
        drain(reset_at);
    endtask

    initial begin
        bus.rx_data_in  = '0;
        bus.rx_valid_in = 1'b0;
        bus.check_en    = 1'b0;
        bus.clear_cnt   = 1'b0;
        model_reset();
        repeat (3) @(posedge data_clk);
        #1;
        check_all();
        @(negedge data_clk);
        reset_n = 1'b1;

        // Lock at offset 7 with an incrementing payload.
        bus.check_en = 1'b1;
        pay = 20'($urandom);
        for (int i = 0; i < 7; i++) bits.push_back(1'($urandom));
        fs_chk = 1;
        repeat (5) frame(1, -1, -1, -1);
        fs_chk = 0;
        chk("lock7_offset", 32'(bus.bit_offset_out), 32'd7);
        chk("lock7_locked", 32'(bus.locked_out), 32'd1);
        chk("lock7_serr", 32'(bus.sync_err_cnt), 32'd0);
        chk("lock7_perr", bus.payload_err_cnt, 32'd0);

        // One corrupted payload word costs two errors; none when checking is off.
        frame(1, 5, -1, -1);
        chk("perr_two", bus.payload_err_cnt, 32'd2);
        chk("perr_serr0", 32'(bus.sync_err_cnt), 32'd0);
        bus.check_en = 1'b0;
        frame(1, 9, -1, -1);
        frame(1, -1, -1, -1);
        bus.check_en = 1'b1;
        frame(1, -1, -1, -1);
        chk("perr_off_unchanged", bus.payload_err_cnt, 32'd2);

        // Loss of lock and relock at a new offset.
        repeat (3) frame(0, -1, -1, -1);
        chk("miss3_locked", 32'(bus.locked_out), 32'd1);
        chk("miss3_serr", 32'(bus.sync_err_cnt), 32'd3);
        frame(1, -1, -1, -1);
        repeat (4) frame(0, -1, -1, -1);
        chk("unlock_locked", 32'(bus.locked_out), 32'd0);
        chk("unlock_loss", 32'(bus.lock_loss_cnt), 32'd1);
        chk("unlock_serr", 32'(bus.sync_err_cnt), 32'd7);
        for (int i = 0; i < 5; i++) bits.push_back(1'($urandom));
        repeat (5) frame(1, -1, -1, -1);
        chk("lock12_offset", 32'(bus.bit_offset_out), 32'd12);
        chk("lock12_locked", 32'(bus.locked_out), 32'd1);

        // Random invalid gaps while locked.
        gap_en = 1;
        repeat (4) frame(1, -1, -1, -1);
        gap_en = 0;
        chk("gap_locked", 32'(bus.locked_out), 32'd1);
        chk("gap_serr", 32'(bus.sync_err_cnt), 32'd7);
        chk("gap_perr", bus.payload_err_cnt, 32'd2);

        // Saturation of the sync error counter.
        force dut.sync_err_q = 16'hFFFF;
        #1;
        release dut.sync_err_q;
        m_serr = 65535;
        frame(0, -1, -1, -1);
        frame(1, -1, -1, -1);
        chk("serr_saturated", 32'(bus.sync_err_cnt), 32'h0000FFFF);

        // Clear wins over a simultaneous increment.
        bus.clear_cnt = 1'b1;
        frame(0, -1, -1, -1);
        bus.clear_cnt = 1'b0;
        frame(1, -1, -1, -1);
        chk("clear_serr", 32'(bus.sync_err_cnt), 32'd0);
        chk("clear_loss", 32'(bus.lock_loss_cnt), 32'd0);

        // Reset mid-frame, a false sync that must not lock, then a full relock.
        frame(1, -1, -1, 6);
        frame(0, -1, 6, -1);
        repeat (2) frame(0, -1, -1, -1);
        chk("false_sync_unlocked", 32'(bus.locked_out), 32'd0);
        repeat (5) frame(1, -1, -1, -1);
        chk("relock_locked", 32'(bus.locked_out), 32'd1);
        chk("relock_offset", 32'(bus.bit_offset_out), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
